// File: rtl/altusoc_wb_uart.sv
// Wishbone 8N1 UART: TX FIFO, single RX holding register, programmable divisor, level irq.
// Bus access acks one cycle after the strobe and never stalls; TX writes into a full FIFO are dropped.
module altusoc_wb_uart #(
  parameter int TX_DEPTH    = 8,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq,
  input  logic        i_rx,
  output logic        o_tx
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] PTR_INC = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic        acc, wr_en, wr_data, wr_stat, wr_ctrl, wr_div, rd_data;
  logic [1:0]  ctrl;
  logic [15:0] div;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_overrun, rx_ferr;
  logic [31:0] rd_mux;
  logic        unused;

  assign acc     = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr_en   = acc & i_wb_we & i_wb_sel[0];
  assign wr_data = wr_en & (i_wb_adr == 2'd0);
  assign wr_stat = wr_en & (i_wb_adr == 2'd1);
  assign wr_ctrl = wr_en & (i_wb_adr == 2'd2);
  assign wr_div  = wr_en & i_wb_sel[1] & (i_wb_adr == 2'd3);
  assign rd_data = acc & ~i_wb_we & (i_wb_adr == 2'd0);
  assign unused  = ^{i_wb_dat[31:16], i_wb_sel[3:2]};

  // TX FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [7:0]  mem [TX_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        fifo_full, fifo_empty, push, tx_pop;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push       = wr_data & ~fifo_full;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= i_wb_dat[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)   wptr <= wptr + PTR_INC;
      if (tx_pop) rptr <= rptr + PTR_INC;
    end
  end

  // TX FSM
  state_t      tx_state;
  logic [15:0] tx_cnt, tx_div_cur;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_end, tx_empty;

  assign tx_end   = (tx_cnt == tx_div_cur - 16'd1);
  assign tx_empty = fifo_empty & (tx_state == IDLE);
  // popping at the end of STOP lets the next start bit follow with no idle gap
  assign tx_pop   = ~fifo_empty & ((tx_state == IDLE) | ((tx_state == STOP) & tx_end));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state   <= IDLE;
      o_tx       <= 1'b1;
      tx_cnt     <= '0;
      tx_div_cur <= 16'(DEFAULT_DIV);
      tx_bit     <= '0;
      tx_sh      <= '0;
    end else begin
      case (tx_state)
        IDLE, STOP: begin
          if (tx_pop) begin
            tx_state   <= START;
            o_tx       <= 1'b0;
            tx_sh      <= mem[rptr[AW-1:0]];
            tx_cnt     <= '0;
            tx_div_cur <= div;
          end else if (tx_state == STOP) begin
            if (tx_end) tx_state <= IDLE;
            else        tx_cnt   <= tx_cnt + 16'd1;
          end
        end
        START: begin
          if (tx_end) begin
            tx_state   <= DATA;
            o_tx       <= tx_sh[0];
            tx_bit     <= '0;
            tx_cnt     <= '0;
            tx_div_cur <= div;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        DATA: begin
          if (tx_end) begin
            tx_cnt     <= '0;
            tx_div_cur <= div;
            if (tx_bit == 3'd7) begin
              tx_state <= STOP;
              o_tx     <= 1'b1;
            end else begin
              o_tx   <= tx_sh[1];
              tx_sh  <= tx_sh >> 1;
              tx_bit <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // RX: two sync flops plus one history flop for edge detection
  state_t      rx_state;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_cnt, rx_div_cur;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_bit_end, rx_stop_smp, rx_deliver, rx_fe;

  assign rx_bit_end  = (rx_cnt == rx_div_cur - 16'd1);
  assign rx_stop_smp = (rx_state == STOP) & rx_bit_end;
  assign rx_deliver  = rx_stop_smp & rx_s2;
  assign rx_fe       = rx_stop_smp & ~rx_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      rx_state   <= IDLE;
      rx_cnt     <= '0;
      rx_div_cur <= 16'(DEFAULT_DIV);
      rx_bit     <= '0;
      rx_sh      <= '0;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        IDLE: begin
          if (~rx_s2 & rx_s3) begin
            rx_state   <= START;
            rx_cnt     <= '0;
            rx_div_cur <= div;
          end
        end
        START: begin
          if (rx_cnt == (rx_div_cur >> 1) - 16'd1) begin
            if (rx_s2) begin
              rx_state <= IDLE;
            end else begin
              rx_state   <= DATA;
              rx_cnt     <= '0;
              rx_bit     <= '0;
              rx_div_cur <= div;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        DATA: begin
          if (rx_bit_end) begin
            rx_sh      <= {rx_s2, rx_sh[7:1]};
            rx_cnt     <= '0;
            rx_div_cur <= div;
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        STOP: begin
          if (rx_bit_end) rx_state <= IDLE;
          else            rx_cnt   <= rx_cnt + 16'd1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (i_wb_adr)
      2'd0: rd_mux = {24'b0, rx_data};
      2'd1: rd_mux = {27'b0, rx_ferr, rx_overrun, rx_valid, tx_empty, fifo_full};
      2'd2: rd_mux = {30'b0, ctrl};
      default: rd_mux = {16'b0, div};
    endcase
  end

  // Registers; a DATA read in the delivery cycle frees the holding register first
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_wb_ack   <= 1'b0;
      o_wb_rdt   <= '0;
      o_irq      <= 1'b0;
      ctrl       <= '0;
      div        <= 16'(DEFAULT_DIV);
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      o_wb_ack <= acc;
      o_wb_rdt <= (acc & ~i_wb_we) ? rd_mux : 32'b0;
      o_irq    <= (ctrl[0] & rx_valid) | (ctrl[1] & tx_empty);
      if (wr_ctrl) ctrl <= i_wb_dat[1:0];
      if (wr_div)  div  <= (i_wb_dat[15:0] < 16'd4) ? 16'd4 : i_wb_dat[15:0];
      if (rx_deliver & (~rx_valid | rd_data)) rx_data <= rx_sh;
      if (rx_deliver)   rx_valid <= 1'b1;
      else if (rd_data) rx_valid <= 1'b0;
      if (rx_deliver & rx_valid & ~rd_data)  rx_overrun <= 1'b1;
      else if (wr_stat & i_wb_dat[3])        rx_overrun <= 1'b0;
      if (rx_fe)                             rx_ferr <= 1'b1;
      else if (wr_stat & i_wb_dat[4])        rx_ferr <= 1'b0;
    end
  end
endmodule

// File: doc/altusoc_wb_uart.md
Name: altusoc_wb_uart

Overview:
- Wishbone-slave UART (8N1) on the SoC Wishbone interconnect, downstream of the AXI-to-Wishbone I/O bridge, next to the system controller.
- Provides a TX FIFO, a single RX holding register, a programmable baud divisor, and a level interrupt for the core's interrupt input.
- Single clock domain; i_rx is asynchronous and is synchronised internally.

Parameters:
- TX_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 868, reset value of the baud divisor in clk cycles per bit (100 MHz / 115200).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_wb_adr  in  2  word address, byte address bits [3:2].
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte selects; a write is honoured only if sel[0]=1; sel[1] also required for DIV writes.
- i_wb_we  in  1  write enable.
- i_wb_cyc  in  1  cycle.
- i_wb_stb  in  1  strobe.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  acknowledge.
- o_irq  out  1  level interrupt.
- i_rx  in  1  serial input, idle high.
- o_tx  out  1  serial output, idle high.

Behaviour:
- Reset values: o_tx=1, o_wb_ack=0, o_wb_rdt=0, o_irq=0; FIFO empty; RX flags clear; CTRL=0; DIV=DEFAULT_DIV; both FSMs IDLE.
- Bus:
  - Access starts when cyc&stb&~ack; o_wb_ack is high exactly one cycle, one cycle later.
  - o_wb_rdt is valid in the ack cycle and zero otherwise.
  - Unused read bits return 0.
  - Every access is acked; there is no error or retry response.
- Register map:
  - 0x0 DATA: write pushes wdat[7:0] into the TX FIFO; a write when full is dropped but still acked. Read returns {24'b0, rx_data} and clears rx_valid. Reading when rx_valid=0 returns the last rx_data with no side effect.
  - 0x4 STATUS: bit0 tx_full, bit1 tx_empty (FIFO empty and TX FSM IDLE), bit2 rx_valid, bit3 rx_overrun, bit4 rx_ferr. Writing 1 to bit3 or bit4 clears that bit (W1C).
  - 0x8 CTRL: bit0 rx_irq_en, bit1 txe_irq_en. Read/write.
  - 0xC DIV: bits[15:0] divisor. Read/write. Writes below 4 are clamped to 4. The new value takes effect at the next bit boundary.
- Interrupt: o_irq registered = (rx_irq_en & rx_valid) | (txe_irq_en & tx_empty).
- TX FSM:
  - States IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty; pop the FIFO head into the shift register in the same cycle.
  - Each state lasts DIV cycles. DATA sends 8 bits LSB first.
  - After STOP, return to IDLE. If the FIFO is non-empty at that point, the next START begins the next cycle with no idle gap.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- RX FSM:
  - 2-flop synchroniser on i_rx.
  - States IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised high-to-low transition.
  - START: sample at DIV/2 (integer division). If the sample is high (glitch), return to IDLE. Otherwise sample each following bit every DIV cycles.
  - STOP: if the stop sample is 0, set rx_ferr and discard the byte. Otherwise deliver it:
    - if rx_valid=0: rx_data←byte, rx_valid←1;
    - if rx_valid=1: set rx_overrun and keep the old rx_data.
  - Delivery in the same cycle as a DATA read: the read clears rx_valid first, then the new byte is loaded and rx_valid stays 1 with no overrun.
  - Return to IDLE after STOP. A new start edge is accepted from the following cycle.
- Reset asserted mid-frame: everything returns to reset values immediately; o_tx goes high asynchronously.

Test Plan:
- Reset, then read 0x4 → 0x00000002; read 0xC → 868; o_tx=1; o_irq=0.
- DIV=4; write 0x55 to DATA → o_tx low for 4 clks (start), then 1,0,1,0,1,0,1,0 each 4 clks, then high 4 clks; STATUS bit1 returns to 1 after 40 clks.
- DIV=4; write TX_DEPTH+2 bytes back-to-back → the last write is dropped while full; exactly TX_DEPTH+1 frames are sent with no gaps (one byte is popped into the shift register before the FIFO fills).
- DIV=4, CTRL=1; drive 0xA3 on i_rx → o_irq=1 and STATUS=0x06; read DATA=0xA3 → o_irq=0 within 2 clks.
- Send two frames without reading → STATUS bit3=1 and DATA still returns the first byte; write 0x08 to 0x4 → bit3 clears.
- Frame with stop bit 0 → rx_ferr=1 and rx_valid stays 0. A 1-clk low glitch on i_rx causes no reception. Reset pulsed mid-TX → o_tx=1 and the FIFO is empty.
